// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared types for the cache-bus arbiter.
//   cbus_req_t  : master -> memory request (valid, address, burst length, write data)
//   cbus_resp_t : memory -> master response (ready, last beat, read data)
//   arb_mode_t  : arbitration policy selector
//   arb_state_t : arbiter FSM states
package cbus_rr_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  len;
    logic [3:0]  strobe;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Age counter width; kept at least 1 bit so MAX_WAIT=0 still elaborates.
  function automatic int age_width(int max_wait);
    return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/cbus_arb_pick.sv
// Combinational winner selection.
//   valid  : per-channel request valid
//   urgent : per-channel aged-out flag (only meaningful where valid)
//   rr_ptr : round-robin start index
//   mode   : ARB_FIXED (lowest index) or ARB_RR (first at/after rr_ptr)
//   winner : selected channel index
//   any    : at least one channel is valid
module cbus_arb_pick
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int IW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [NUM_CH-1:0] urgent,
  input  logic [IW-1:0]     rr_ptr,
  input  arb_mode_t         mode,
  output logic [IW-1:0]     winner,
  output logic              any
);

  logic [NUM_CH-1:0] hot;
  logic [NUM_CH-1:0] cand;
  logic [IW:0]       idx;
  logic              found;

  // Urgent requesters shadow everyone else; otherwise every valid competes.
  assign hot  = valid & urgent;
  assign cand = (|hot) ? hot : valid;
  assign any  = |valid;

  // Scan NUM_CH slots starting at 0 (fixed) or rr_ptr (round robin),
  // wrapping modulo NUM_CH. idx has one spare bit to hold rr_ptr+k.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (mode == ARB_RR) ? ({1'b0, rr_ptr} + (IW+1)'(k)) : (IW+1)'(k);
      if (idx >= (IW+1)'(NUM_CH)) idx = idx - (IW+1)'(NUM_CH);
      if (!found && cand[idx[IW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-way cache-bus arbiter: merges NUM_CH masters onto one memory port.
// A grant is held for a whole burst and released on oresp.ready && oresp.last.
//   clk, resetn : clock, synchronous active-low reset
//   ireqs       : per-channel requests, index 0 = highest fixed priority
//   iresps      : per-channel responses (only the granted channel sees oresp)
//   oreq        : merged request to memory (combinational from ireqs[sel])
//   oresp       : response from memory
// Parameters: NUM_CH (>=2), MODE (0 fixed, 1 round robin),
//             MAX_WAIT (lost arbitrations before urgent, 0 disables aging).
module cbus_rr_arbiter
  import cbus_rr_arbiter_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int MODE     = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  cbus_req_t [NUM_CH-1:0]  ireqs,
  output cbus_resp_t [NUM_CH-1:0] iresps,
  output cbus_req_t               oreq,
  input  cbus_resp_t              oresp
);

  localparam int        IW       = $clog2(NUM_CH);
  localparam int        AW       = age_width(MAX_WAIT);
  localparam arb_mode_t ARB_MODE = (MODE == 1) ? ARB_RR : ARB_FIXED;
  localparam logic [AW-1:0] AGE_MAX = AW'(MAX_WAIT);

  arb_state_t state, state_nxt;
  logic [IW-1:0] sel, sel_nxt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic [NUM_CH-1:0][AW-1:0] age, age_nxt;

  logic [NUM_CH-1:0] valid;
  logic [NUM_CH-1:0] urgent;
  logic [IW-1:0]     winner;
  logic              any;
  logic              busy;
  logic              rel;

  assign busy = (state == ST_BUSY);
  assign rel  = busy && oresp.ready && oresp.last;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign valid[i]  = ireqs[i].valid;
    assign urgent[i] = (MAX_WAIT > 0) && (age[i] == AGE_MAX);
  end

  cbus_arb_pick #(
    .NUM_CH (NUM_CH),
    .IW     (IW)
  ) u_pick (
    .valid  (valid),
    .urgent (urgent),
    .rr_ptr (rr_ptr),
    .mode   (ARB_MODE),
    .winner (winner),
    .any    (any)
  );

  // Next-state: grant/release FSM plus pointer update on release.
  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (any) begin
          sel_nxt   = winner;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (oresp.ready && oresp.last) begin
          state_nxt  = ST_IDLE;
          rr_ptr_nxt = (sel == IW'(NUM_CH - 1)) ? '0 : sel + IW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Aging: an idle channel forgets its wait; losers of a release age by one
  // (saturating); the channel just served starts over.
  always_comb begin
    age_nxt = age;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!valid[i]) begin
        age_nxt[i] = '0;
      end else if (rel) begin
        if (sel == IW'(i))           age_nxt[i] = '0;
        else if (age[i] != AGE_MAX)  age_nxt[i] = age[i] + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      sel    <= '0;
      rr_ptr <= '0;
      age    <= '0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      rr_ptr <= rr_ptr_nxt;
      age    <= age_nxt;
    end
  end

  // Request passes through unregistered so beats see no added latency.
  assign oreq = busy ? ireqs[sel] : '0;

  always_comb begin
    iresps = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (busy && (sel == IW'(i))) iresps[i] = oresp;
    end
  end

endmodule
